// File: rtl/picorv32_arb_pkg.sv
// rtl/picorv32_arb_pkg.sv - shared types and constants for the picorv32 memory arbiter
//
// Purpose: arbiter state encoding, master identifiers, default watchdog
//          settings and a counter-width helper used by the arbiter and its
//          watchdog.
// Ports:   none (package).
package picorv32_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_AUX  = 1'b1;

  localparam int          DEFAULT_TIMEOUT   = 1024;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  // Width able to hold 0..t; never narrower than one bit so a disabled
  // watchdog (t == 0) still elaborates.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/picorv32_mem_arbiter_watchdog.sv
// rtl/picorv32_mem_arbiter_watchdog.sv - saturating busy-cycle counter with expiry flag
//
// Purpose: counts cycles while enabled and flags the cycle in which the
//          count reaches TIMEOUT-1. TIMEOUT == 0 disables expiry.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   i_clear   in   zero the counter (takes priority over i_enable)
//   i_enable  in   count this cycle
//   o_expire  out  enabled and count == TIMEOUT-1
module mem_watchdog
  import picorv32_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] r_count;

  // Saturates at all-ones instead of wrapping, so a long stall can never
  // alias back onto the expiry value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign o_expire = 1'b0;
    end else begin : g_enabled
      localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
      assign o_expire = i_enable && (r_count == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-master round-robin arbiter for one native memory slave
//
// Purpose: shares a valid/ready memory slave between the core (master 0)
//          and an auxiliary requester (master 1). Requests are captured at
//          grant, ties go to the master not served last, and a watchdog
//          force-completes a transaction the slave never acknowledges.
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   m0_* / m1_*                    master request (valid/addr/wdata/wstrb/instr)
//                                  and response (ready pulse, rdata)
//   s_valid/s_addr/s_wdata/
//   s_wstrb/s_instr                registered slave request
//   s_ready/s_rdata                slave completion and read data
//   grant_id                       owning master, meaningful in BUSY
//   timeout_err                    one-cycle pulse on forced completion
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = DEFAULT_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_instr,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_instr,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_instr,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                grant_id,
  output logic                timeout_err
);

  arb_state_t r_state, w_state_nxt;

  logic r_last;
  logic r_grant;
  logic r_s_valid;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]   r_s_wdata;
  logic [DATA_W/8-1:0] r_s_wstrb;
  logic                r_s_instr;
  logic [DATA_W-1:0]   r_m0_hold;
  logic [DATA_W-1:0]   r_m1_hold;

  logic              w_grant_en;
  logic              w_grant_sel;
  logic              w_busy;
  logic              w_expire;
  logic              w_forced;
  logic              w_complete;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy     = (r_state == BUSY);
  // A real acknowledge in the expiry cycle wins and carries slave data.
  assign w_forced   = w_busy && w_expire && !s_ready;
  assign w_complete = w_busy && (s_ready || w_expire);
  assign w_rdata    = w_forced ? ERR_RDATA : s_rdata;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_grant_en),
    .i_enable (w_busy),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant_sel = M_CORE;
    unique case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          w_grant_en  = 1'b1;
          w_grant_sel = ~r_last;
        end else if (m0_valid) begin
          w_grant_en  = 1'b1;
          w_grant_sel = M_CORE;
        end else if (m1_valid) begin
          w_grant_en  = 1'b1;
          w_grant_sel = M_AUX;
        end
        if (w_grant_en) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (s_ready || w_expire) w_state_nxt = DONE;
      end
      DONE: begin
        // r_last already names the master just served; only the other
        // one may be granted back-to-back.
        if (r_last ? m0_valid : m1_valid) begin
          w_grant_en  = 1'b1;
          w_grant_sel = ~r_last;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= M_AUX;
      r_grant   <= M_CORE;
      r_s_valid <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
      r_s_instr <= 1'b0;
      r_m0_hold <= '0;
      r_m1_hold <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_valid <= (w_state_nxt == BUSY);
      if (w_grant_en) begin
        r_grant   <= w_grant_sel;
        r_s_addr  <= w_grant_sel ? m1_addr  : m0_addr;
        r_s_wdata <= w_grant_sel ? m1_wdata : m0_wdata;
        r_s_wstrb <= w_grant_sel ? m1_wstrb : m0_wstrb;
        r_s_instr <= w_grant_sel ? m1_instr : m0_instr;
      end
      if (w_complete) r_last <= r_grant;
      if (m0_ready) r_m0_hold <= w_rdata;
      if (m1_ready) r_m1_hold <= w_rdata;
    end
  end

  assign m0_ready = w_complete && (r_grant == M_CORE);
  assign m1_ready = w_complete && (r_grant == M_AUX);

  // Outside its own transaction a master sees the last data it was given,
  // so its rdata never follows another master's traffic.
  assign m0_rdata = (w_busy && (r_grant == M_CORE)) ? w_rdata : r_m0_hold;
  assign m1_rdata = (w_busy && (r_grant == M_AUX))  ? w_rdata : r_m1_hold;

  assign s_valid     = r_s_valid;
  assign s_addr      = r_s_addr;
  assign s_wdata     = r_s_wdata;
  assign s_wstrb     = r_s_wstrb;
  assign s_instr     = r_s_instr;
  assign grant_id    = r_grant;
  assign timeout_err = w_forced;

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Two-master arbiter that shares one native-interface memory slave (valid/ready/addr/wdata/wstrb/rdata/instr) between the core (master 0) and a second requester (master 1, a loader or DMA).
- Sits between the core wrapper and the memory/MMIO decode.
- Round-robin grant, transaction capture and a watchdog timeout, so a hung slave does not stall the core forever.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT, 1024, cycles in BUSY without s_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on a timed-out transaction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  master 0 request.
- m0_ready  out  1  master 0 completion pulse.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 = read.
- m0_instr  in  1  master 0 instruction-fetch flag.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_instr, m1_rdata  same as m0_* for master 1.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_addr  out  ADDR_W  captured address.
- s_wdata  out  DATA_W  captured write data.
- s_wstrb  out  DATA_W/8  captured strobes.
- s_instr  out  1  captured instr flag.
- s_rdata  in  DATA_W  slave read data.
- grant_id  out  1  master currently owning the slave; valid in BUSY.
- timeout_err  out  1  one-cycle pulse on forced completion.

Behaviour:
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first tie).
  - s_valid=0; s_addr/s_wdata/s_wstrb/s_instr=0; grant_id=0.
  - Timeout counter=0; timeout_err=0; m*_ready=0.
- State IDLE:
  - Sample m0_valid/m1_valid.
  - If exactly one is high, grant it.
  - If both are high, grant !last.
  - On grant: register the master's addr/wdata/wstrb/instr into s_*, set grant_id, clear the counter, go to BUSY.
  - If neither is high, stay in IDLE.
- State BUSY:
  - s_valid=1 (registered).
  - mX_ready = s_ready for the granted master only (combinational); mX_rdata = s_rdata.
  - The non-granted master sees ready=0, and its rdata is undefined but stable.
  - Counter increments each BUSY cycle.
  - On s_ready: set last=grant_id, go to DONE.
  - Watchdog (TIMEOUT≠0): when counter==TIMEOUT-1 and s_ready=0, assert granted mX_ready=1 with mX_rdata=ERR_RDATA, pulse timeout_err, set last=grant_id, go to DONE.
  - s_ready and expiry in the same cycle: s_ready wins, with no error.
- State DONE (one cycle):
  - s_valid=0.
  - The just-served master's valid is ignored; the other master may be granted directly (same rules as IDLE, excluding the served master). Otherwise go to IDLE.
  - This covers the core deasserting mem_valid one cycle after ready.
- Latency: request visible in IDLE → s_valid the next cycle. Zero-wait slave gives 2 cycles from request to mX_ready; minimum transaction spacing is 3 cycles per master.
- Masters must hold addr/wdata/wstrb/instr stable while valid is high. The arbiter captures them at grant and never re-samples them during BUSY.
- A master dropping valid during BUSY does not abort the transaction; the slave access completes and the ready pulse is still issued.
- Asynchronous reset mid-transaction returns everything to reset values immediately; no ready is issued for the aborted transaction.
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package picorv32_arb_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Master ID constants M_CORE=0, M_AUX=1.
  - Default TIMEOUT and ERR_RDATA localparams.
- One sub-module, mem_watchdog: counter with clear/enable inputs and an expire output.

Test Plan:
- Only m0_valid, addr=0x100, wstrb=0, slave ready after 2 cycles with rdata=0x12345678 → s_addr=0x100, m0_ready for 1 cycle, m0_rdata=0x12345678, m1_ready stays 0.
- m0 and m1 both valid from reset → m0 served first, then m1 granted in DONE; next simultaneous request goes to m0 again (alternating).
- m1 write, addr=0x2000, wdata=0xA5A5A5A5, wstrb=0xF → s_* match exactly; m0 requesting mid-BUSY waits until m1 completes.
- TIMEOUT=8, slave never readies → m0_ready on the 8th BUSY cycle, m0_rdata=0xDEADBEEF, timeout_err single pulse.
- s_ready on cycle TIMEOUT-1 → normal completion with slave data, timeout_err=0.
- reset asserted during BUSY → s_valid=0 and state IDLE within the same cycle (asynchronous); no m*_ready; clean grant after release.
